// File: rtl/shift_register_piso.sv
// Parallel-in serial-out transmit shift register with a one-word holding buffer.
// Latency: word accepted at edge N puts its first bit on o_serial_out after edge N+1.
// Backpressure: o_ready drops while the holding buffer is full. A word offered with o_ready low is ignored.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_data       parallel word, sampled on the accept edge (i_valid & o_ready)
//   i_valid      i_data carries a word to transmit
//   o_ready      holding buffer empty; driven straight from a register
//   o_serial_out registered serial data; 0 whenever no frame bit is on the line
//   o_active     high while a frame bit is on o_serial_out
//   o_done       one-cycle pulse after the last bit period of a word completes
module shift_register_piso #(
    parameter int WORD_SIZE    = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter bit MSB_FIRST    = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_serial_out,
    output logic                 o_active,
    output logic                 o_done
);

    localparam int BIT_W = $clog2(WORD_SIZE);
    localparam int PER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_SIZE - 1);
    localparam logic [PER_W-1:0] LAST_PER = PER_W'(CLKS_PER_BIT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] buf_data;
    logic                 buf_full;
    logic [WORD_SIZE-1:0] shifter;
    logic [BIT_W-1:0]     bit_cnt;
    logic [PER_W-1:0]     per_cnt;

    logic                 accept;
    logic                 bit_end;
    logic                 word_end;
    logic                 load_word;
    logic [WORD_SIZE-1:0] shifted;

    // Bit that goes on the line first for a given shifter image.
    function automatic logic lead_bit(input logic [WORD_SIZE-1:0] w);
        return MSB_FIRST ? w[WORD_SIZE-1] : w[0];
    endfunction

    // Move the next bit into the lead position.
    function automatic logic [WORD_SIZE-1:0] advance(input logic [WORD_SIZE-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign o_ready  = ~buf_full;
    assign accept   = i_valid & ~buf_full;
    assign bit_end  = (per_cnt == LAST_PER);
    assign word_end = (state == SHIFT) && bit_end && (bit_cnt == LAST_BIT);
    assign shifted  = advance(shifter);

    // The buffer drains into the shifter either from IDLE or at the end of the
    // current word; draining at word end is what keeps back-to-back frames gap-free.
    // Draining requires a full buffer and accepting requires an empty one, so the
    // two never collide on the same edge.
    assign load_word = buf_full && ((state == IDLE) || word_end);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            buf_data     <= '0;
            buf_full     <= 1'b0;
            shifter      <= '0;
            bit_cnt      <= '0;
            per_cnt      <= '0;
            o_serial_out <= 1'b0;
            o_active     <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            // A word is done only when its final bit period has fully elapsed.
            o_done <= word_end;

            if (accept) begin
                buf_data <= i_data;
                buf_full <= 1'b1;
            end

            if (load_word) begin
                shifter      <= buf_data;
                o_serial_out <= lead_bit(buf_data);
                o_active     <= 1'b1;
                bit_cnt      <= '0;
                per_cnt      <= '0;
                buf_full     <= 1'b0;
                state        <= SHIFT;
            end else begin
                case (state)
                    IDLE: begin
                        o_serial_out <= 1'b0;
                        o_active     <= 1'b0;
                    end
                    SHIFT: begin
                        if (!bit_end) begin
                            per_cnt <= per_cnt + PER_W'(1);
                        end else if (bit_cnt != LAST_BIT) begin
                            per_cnt      <= '0;
                            shifter      <= shifted;
                            o_serial_out <= lead_bit(shifted);
                            bit_cnt      <= bit_cnt + BIT_W'(1);
                        end else begin
                            // Word end with nothing buffered: release the line.
                            per_cnt      <= '0;
                            bit_cnt      <= '0;
                            o_serial_out <= 1'b0;
                            o_active     <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_register_piso.sv
// Bench for shift_register_piso: four instances with different word size,
// bit period and bit order, driven with directed and random words; a
// scoreboard queue of expected line samples is drained by a monitor process.
module tb_shift_register_piso;

    localparam int ND = 4;
    localparam int SZ = 8192;

    // Per-instance configuration, mirrored in the instance parameters below.
    int WS   [ND] = '{8, 8, 16, 8};
    int CPBS [ND] = '{1, 4, 2, 1};
    int MSBF [ND] = '{0, 0, 1, 1};

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   data [ND];
    logic [ND-1:0] valid;
    logic [ND-1:0] ready;
    logic [ND-1:0] serial;
    logic [ND-1:0] active;
    logic [ND-1:0] done;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected line samples per instance: one entry per clock of a frame bit.
    bit exp_bits [ND][SZ];
    bit exp_last [ND][SZ];
    int wr [ND];
    int rd [ND];
    bit done_pend [ND];

    always #5 clk = ~clk;

    shift_register_piso #(.WORD_SIZE(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b0)) u_d0 (
        .i_clk(clk), .i_rst(rst), .i_data(data[0][7:0]), .i_valid(valid[0]),
        .o_ready(ready[0]), .o_serial_out(serial[0]), .o_active(active[0]), .o_done(done[0]));

    shift_register_piso #(.WORD_SIZE(8), .CLKS_PER_BIT(4), .MSB_FIRST(1'b0)) u_d1 (
        .i_clk(clk), .i_rst(rst), .i_data(data[1][7:0]), .i_valid(valid[1]),
        .o_ready(ready[1]), .o_serial_out(serial[1]), .o_active(active[1]), .o_done(done[1]));

    shift_register_piso #(.WORD_SIZE(16), .CLKS_PER_BIT(2), .MSB_FIRST(1'b1)) u_d2 (
        .i_clk(clk), .i_rst(rst), .i_data(data[2]), .i_valid(valid[2]),
        .o_ready(ready[2]), .o_serial_out(serial[2]), .o_active(active[2]), .o_done(done[2]));

    shift_register_piso #(.WORD_SIZE(8), .CLKS_PER_BIT(1), .MSB_FIRST(1'b1)) u_d3 (
        .i_clk(clk), .i_rst(rst), .i_data(data[3][7:0]), .i_valid(valid[3]),
        .o_ready(ready[3]), .o_serial_out(serial[3]), .o_active(active[3]), .o_done(done[3]));

    task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, got, exp, $time);
        end
    endtask

    // Reference model: a word becomes WORD_SIZE bits in send order, each
    // repeated for its bit period; the last sample of a word is tagged so the
    // monitor knows a done pulse follows.
    task automatic push_word(input int d, input logic [15:0] w);
        for (int i = 0; i < WS[d]; i++) begin
            int idx = (MSBF[d] != 0) ? (WS[d] - 1 - i) : i;
            for (int c = 0; c < CPBS[d]; c++) begin
                exp_bits[d][wr[d] % SZ] = w[idx];
                exp_last[d][wr[d] % SZ] = (i == WS[d] - 1) && (c == CPBS[d] - 1);
                wr[d]++;
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (rst) begin
                    rd[d] = wr[d];
                    done_pend[d] = 1'b0;
                end else begin
                    chk("done_pulse", d, done[d], done_pend[d]);
                    done_pend[d] = 1'b0;
                    if (active[d]) begin
                        chk("active_with_data", d, active[d], rd[d] != wr[d]);
                        if (rd[d] != wr[d]) begin
                            chk("serial_bit", d, serial[d], exp_bits[d][rd[d] % SZ]);
                            done_pend[d] = exp_last[d][rd[d] % SZ];
                            rd[d]++;
                        end
                    end else begin
                        chk("idle_serial", d, serial[d], 0);
                    end
                end
            end
        end
    endtask

    task automatic send(input int d, input logic [15:0] w);
        int waited = 0;
        @(negedge clk);
        data[d]  = w;
        valid[d] = 1'b1;
        while (!ready[d] && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!ready[d]) begin
            chk("accept_timeout", d, ready[d], 1);
        end else begin
            push_word(d, w);
            @(posedge clk);
        end
        #1;
        valid[d] = 1'b0;
        data[d]  = 16'($urandom);
    endtask

    // Waits for a frame run, then reports: idle samples before it, active
    // samples in it, done pulses seen, and spacing between the first two.
    task automatic measure(input int d, output int lat, output int run, output int ndone, output int gap);
        int first_at = -1;
        lat = 0; run = 0; ndone = 0; gap = 0;
        @(negedge clk);
        while (!active[d] && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        while (active[d] && run < 2000) begin
            if (done[d]) begin
                ndone++;
                if (first_at < 0) first_at = run; else if (ndone == 2) gap = run - first_at;
            end
            run++;
            @(negedge clk);
        end
        if (done[d]) begin
            ndone++;
            if (first_at < 0) first_at = run; else if (ndone == 2) gap = run - first_at;
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while ((active[d] || !ready[d]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", d, active[d], 0);
    endtask

    task automatic random_words(input int d, input int count);
        logic [15:0] mask;
        mask = (WS[d] == 16) ? 16'hFFFF : 16'h00FF;
        for (int k = 0; k < count; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(d, 16'($urandom) & mask);
        end
    endtask

    initial begin
        int lat, run, ndone, gap;
        rst   = 1'b1;
        valid = '0;
        for (int d = 0; d < ND; d++) begin
            data[d] = '0;
            wr[d] = 0;
            rd[d] = 0;
            done_pend[d] = 1'b0;
        end

        fork
            monitor();
            begin
                #300000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state on every instance.
        #3;
        for (int d = 0; d < ND; d++) begin
            chk("rst_ready", d, ready[d], 1);
            chk("rst_active", d, active[d], 0);
            chk("rst_serial", d, serial[d], 0);
            chk("rst_done", d, done[d], 0);
        end
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Single word, one clock per bit: A5 -> 1,0,1,0,0,1,0,1.
        send(0, 16'h00A5);
        measure(0, lat, run, ndone, gap);
        chk("t1_latency", 0, lat, 1);
        chk("t1_run", 0, run, 8);
        chk("t1_done_count", 0, ndone, 1);
        wait_idle(0);

        // Back-to-back 3C then FF: 16 contiguous bits, done pulses 8 apart.
        send(0, 16'h003C);
        fork
            measure(0, lat, run, ndone, gap);
            send(0, 16'h00FF);
        join
        chk("t2_run", 0, run, 16);
        chk("t2_done_count", 0, ndone, 2);
        chk("t2_done_gap", 0, gap, 8);
        wait_idle(0);

        // Four clocks per bit: 01 -> high 4, low 28, done after 32.
        send(1, 16'h0001);
        measure(1, lat, run, ndone, gap);
        chk("t3_latency", 1, lat, 1);
        chk("t3_run", 1, run, 32);
        chk("t3_done_count", 1, ndone, 1);
        wait_idle(1);

        // Backpressure: 11 shifting, 22 buffered, 33 held off until 22 loads.
        send(0, 16'h0011);
        send(0, 16'h0022);
        @(negedge clk);
        data[0]  = 16'h0033;
        valid[0] = 1'b1;
        #1;
        chk("t4_ready_low", 0, ready[0], 0);
        send(0, 16'h0033);
        wait_idle(0);
        chk("t4_drained", 0, rd[0], wr[0]);

        // Reset in the middle of F0, then 0F from bit 0.
        send(0, 16'h00F0);
        measure(0, lat, run, ndone, gap);
        wait_idle(0);
        send(0, 16'h00F0);
        @(negedge clk);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_active", 0, active[0], 0);
        chk("t5_rst_serial", 0, serial[0], 0);
        chk("t5_rst_done", 0, done[0], 0);
        chk("t5_rst_ready", 0, ready[0], 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        send(0, 16'h000F);
        measure(0, lat, run, ndone, gap);
        chk("t5_run", 0, run, 8);
        chk("t5_done_count", 0, ndone, 1);
        wait_idle(0);

        // MSB-first: 80 on 8-bit, 8001 on 16-bit with two clocks per bit.
        send(3, 16'h0080);
        measure(3, lat, run, ndone, gap);
        chk("t6_run8", 3, run, 8);
        chk("t6_done8", 3, ndone, 1);
        send(2, 16'h8001);
        measure(2, lat, run, ndone, gap);
        chk("t6_run16", 2, run, 32);
        chk("t6_done16", 2, ndone, 1);

        // Random traffic with random gaps on all instances at once.
        fork
            random_words(0, 40);
            random_words(1, 20);
            random_words(2, 20);
            random_words(3, 40);
        join
        for (int d = 0; d < ND; d++) wait_idle(d);
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            chk("final_drained", d, rd[d], wr[d]);
            chk("final_ready", d, ready[d], 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
